// File: rtl/rythm_game_ctrl_pkg.sv
// Shared definitions for the rhythm-game controller.
//   state_e      : top-level mode encoding
//   LCD_* / LED_*: screen codes and LED drive levels shared with the LCD/LED blocks
//   disp_t       : registered display bundle (LCD code + RGB levels)
//   disp_decode  : state -> display bundle
package rythm_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORE  = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  localparam logic [2:0] LCD_IDLE   = 3'b000;
  localparam logic [2:0] LCD_PLAY   = 3'b001;
  localparam logic [2:0] LCD_SCORE  = 3'b010;
  localparam logic [2:0] LCD_RESULT = 3'b011;

  localparam logic [1:0] LED_ON  = 2'b10;
  localparam logic [1:0] LED_OFF = 2'b00;

  typedef struct packed {
    logic [2:0] lcd;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } disp_t;

  function automatic disp_t disp_decode(input state_e s);
    disp_t d;
    d = '{lcd: LCD_IDLE, r: LED_ON, g: LED_OFF, b: LED_OFF};
    case (s)
      ST_PLAY:   d = '{lcd: LCD_PLAY,   r: LED_OFF, g: LED_ON,  b: LED_OFF};
      ST_SCORE:  d = '{lcd: LCD_SCORE,  r: LED_OFF, g: LED_OFF, b: LED_ON};
      ST_RESULT: d = '{lcd: LCD_RESULT, r: LED_ON,  g: LED_ON,  b: LED_OFF};
      default:   d = '{lcd: LCD_IDLE,   r: LED_ON,  g: LED_OFF, b: LED_OFF};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rythm_game_ctrl_if.sv
// Note ROM bus between the controller and the external synchronous song ROM.
//   note_addr : song*SONG_LEN + idx, driven by the controller
//   note_data : expected note, returned one cycle after note_addr; 0 = rest
interface rythm_game_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int KEY_W  = 8
);
  logic [ADDR_W-1:0] note_addr;
  logic [KEY_W-1:0]  note_data;

  modport master (output note_addr, input  note_data);
  modport slave  (input  note_addr, output note_data);
endinterface

// File: rtl/rythm_game_ctrl_input_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
//   din  : asynchronous level inputs
//   lvl  : synchronised level, aligned with rise
//   rise : one-cycle pulse per 0->1 transition, three clocks after din
module rythm_input_sync #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic [W-1:0] din,
  output logic [W-1:0] lvl,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] rise_q, rise_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  // prev_q is the level that rise_q was computed against, so both line up
  assign lvl  = prev_q;
  assign rise = rise_q;

endmodule

// File: rtl/rythm_game_ctrl.sv
// Rhythm-game top: mode FSM, beat/idx counters, hit judging, saturating
// score, best-score tracking and registered LCD/LED decode.
//   CLK, RESETN            : clock, async active-low reset
//   menu_play/score, back  : DIP levels, synchronised + edge detected
//   sel                    : song select, latched on PLAY entry
//   key                    : key levels, 1 = pressed
//   rom                    : note ROM bus (address out, data back 1 cycle later)
//   state_lcd, R/G/B_IN    : registered screen code and LED levels
//   score, best_score      : current game score, best completed score
//   sound_effect           : 1-cycle pulse on hit
//   beat_tick              : 1-cycle pulse on last cycle of each PLAY beat
module rythm_game_ctrl
  import rythm_game_ctrl_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int SONG_LEN  = 32,
  parameter int BEAT_CYC  = 5_000_000,
  parameter int KEY_W     = 8,
  parameter int SCORE_W   = 8
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         menu_play,
  input  logic                         menu_score,
  input  logic                         back,
  input  logic [$clog2(NUM_SONGS)-1:0] sel,
  input  logic [KEY_W-1:0]             key,
  rythm_game_ctrl_if.master            rom,
  output logic [2:0]                   state_lcd,
  output logic [1:0]                   R_IN,
  output logic [1:0]                   G_IN,
  output logic [1:0]                   B_IN,
  output logic [SCORE_W-1:0]           score,
  output logic [SCORE_W-1:0]           best_score,
  output logic                         sound_effect,
  output logic                         beat_tick
);

  localparam int SEL_W  = $clog2(NUM_SONGS);
  localparam int IDX_W  = $clog2(SONG_LEN);
  localparam int CNT_W  = $clog2(BEAT_CYC);
  localparam int ADDR_W = $clog2(NUM_SONGS * SONG_LEN);

  // lane 0 = play, 1 = score, 2 = back
  logic [2:0]       menu_in, menu_lvl, menu_rise;
  logic [KEY_W-1:0] key_lvl, key_rise;

  assign menu_in = {back, menu_score, menu_play};

  rythm_input_sync #(.W(1)) u_menu_sync [2:0] (
    .CLK    (CLK),
    .RESETN (RESETN),
    .din    (menu_in),
    .lvl    (menu_lvl),
    .rise   (menu_rise)
  );

  rythm_input_sync #(.W(KEY_W)) u_key_sync (
    .CLK    (CLK),
    .RESETN (RESETN),
    .din    (key),
    .lvl    (key_lvl),
    .rise   (key_rise)
  );

  // a rise pulse always coincides with its aligned level being high
  logic play_ev, score_ev, back_ev, key_ev;
  assign play_ev  = menu_rise[0] & menu_lvl[0];
  assign score_ev = menu_rise[1] & menu_lvl[1];
  assign back_ev  = menu_rise[2] & menu_lvl[2];
  assign key_ev   = |key_rise;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               judged_q, judged_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               se_q, se_d;
  disp_t              disp_q, disp_d;

  logic last_cyc;
  assign last_cyc  = (cnt_q == CNT_W'(BEAT_CYC - 1));
  assign beat_tick = (state_q == ST_PLAY) && last_cyc;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    judged_d = judged_q;
    score_d  = score_q;
    best_d   = best_q;
    se_d     = 1'b0;
    disp_d   = disp_decode(state_q);

    case (state_q)
      ST_IDLE: begin
        if (back_ev) begin
          state_d = ST_IDLE;
        end else if (play_ev) begin
          state_d  = ST_PLAY;
          sel_d    = sel;
          idx_d    = '0;
          cnt_d    = '0;
          judged_d = 1'b0;
          score_d  = '0;
        end else if (score_ev) begin
          state_d = ST_SCORE;
        end
      end

      ST_PLAY: begin
        if (back_ev) begin
          state_d = ST_IDLE;
        end else begin
          // note_data is only valid from the second cycle of a beat
          if (key_ev && (cnt_q != '0) && (rom.note_data != '0) && !judged_q) begin
            judged_d = 1'b1;
            if (key_lvl == rom.note_data) begin
              se_d = 1'b1;
              if (score_q != '1) score_d = score_q + 1'b1;
            end
          end
          // judge above first so a press on the tick cycle counts for the ending beat
          if (last_cyc) begin
            cnt_d    = '0;
            judged_d = 1'b0;
            if (idx_q == IDX_W'(SONG_LEN - 1)) begin
              state_d = ST_RESULT;
              best_d  = (score_d > best_q) ? score_d : best_q;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_SCORE: begin
        if (back_ev) state_d = ST_IDLE;
      end

      ST_RESULT: begin
        if (back_ev || play_ev) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      judged_q <= 1'b0;
      score_q  <= '0;
      best_q   <= '0;
      se_q     <= 1'b0;
      disp_q   <= disp_decode(ST_IDLE);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      judged_q <= judged_d;
      score_q  <= score_d;
      best_q   <= best_d;
      se_q     <= se_d;
      disp_q   <= disp_d;
    end
  end

  assign rom.note_addr = ADDR_W'(sel_q) * ADDR_W'(SONG_LEN) + ADDR_W'(idx_q);

  assign state_lcd    = disp_q.lcd;
  assign R_IN         = disp_q.r;
  assign G_IN         = disp_q.g;
  assign B_IN         = disp_q.b;
  assign score        = score_q;
  assign best_score   = best_q;
  assign sound_effect = se_q;

endmodule

// File: tb/tb_rythm_game_ctrl.sv
// Directed bench: main instance (SONG_LEN=4, SCORE_W=8) covers mode flow,
// judging and best score; a second instance (SONG_LEN=8, SCORE_W=2) shares
// the stimulus and covers score saturation and asynchronous reset.
module tb_rythm_game_ctrl;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       menu_play = 1'b0, menu_score = 1'b0, back = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] key = 8'h00;

  logic [2:0] m_lcd, s_lcd;
  logic [1:0] m_r, m_g, m_b, s_r, s_g, s_b;
  logic [7:0] m_score, m_best;
  logic [1:0] s_score, s_best;
  logic       m_se, m_tick, s_se, s_tick;

  rythm_game_ctrl_if #(.ADDR_W(3), .KEY_W(8)) rom_if ();
  rythm_game_ctrl_if #(.ADDR_W(4), .KEY_W(8)) sat_if ();

  rythm_game_ctrl #(.NUM_SONGS(2), .SONG_LEN(4), .BEAT_CYC(4), .KEY_W(8), .SCORE_W(8)) u_dut (
    .CLK(CLK), .RESETN(RESETN), .menu_play(menu_play), .menu_score(menu_score), .back(back),
    .sel(sel), .key(key), .rom(rom_if), .state_lcd(m_lcd), .R_IN(m_r), .G_IN(m_g), .B_IN(m_b),
    .score(m_score), .best_score(m_best), .sound_effect(m_se), .beat_tick(m_tick)
  );

  rythm_game_ctrl #(.NUM_SONGS(2), .SONG_LEN(8), .BEAT_CYC(4), .KEY_W(8), .SCORE_W(2)) u_sat (
    .CLK(CLK), .RESETN(RESETN), .menu_play(menu_play), .menu_score(menu_score), .back(back),
    .sel(sel), .key(key), .rom(sat_if), .state_lcd(s_lcd), .R_IN(s_r), .G_IN(s_g), .B_IN(s_b),
    .score(s_score), .best_score(s_best), .sound_effect(s_se), .beat_tick(s_tick)
  );

  always #5 CLK = ~CLK;

  // song 0 = {01,01,01,01}, song 1 = {01,02,00,08}; sat ROM all 01
  logic [7:0] rom_m [8];
  logic [7:0] rom_s [16];
  initial begin
    rom_m[0] = 8'h01; rom_m[1] = 8'h01; rom_m[2] = 8'h01; rom_m[3] = 8'h01;
    rom_m[4] = 8'h01; rom_m[5] = 8'h02; rom_m[6] = 8'h00; rom_m[7] = 8'h08;
    for (int i = 0; i < 16; i++) rom_s[i] = 8'h01;
  end
  always @(posedge CLK) rom_if.note_data <= rom_m[rom_if.note_addr];
  always @(posedge CLK) sat_if.note_data <= rom_s[sat_if.note_addr];

  int se_cnt = 0;
  always @(negedge CLK) if (m_se) se_cnt <= se_cnt + 1;

  int n_chk = 0, n_err = 0, se_base = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // press schedule: beat b is pressed with p1[b] at step 3+4b (edge at cnt 2),
  // switched to p2[b] at 4+4b (edge at cnt 3 if it adds bits), released at 5+4b
  logic [7:0] p1 [8];
  logic [7:0] p2 [8];

  task automatic set_presses(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    p1[0] = a0; p1[1] = a1; p1[2] = a2; p1[3] = a3;
    p2[0] = b0; p2[1] = b1; p2[2] = b2; p2[3] = b3;
    for (int i = 4; i < 8; i++) begin p1[i] = 8'h00; p2[i] = 8'h00; end
  endtask

  // step k of a game whose menu_play rise was driven at step 0; PLAY starts at step 4
  task automatic step_game(input int k);
    tick();
    if (k == 2) begin menu_play = 1'b0; menu_score = 1'b0; end
    for (int b = 0; b < 8; b++) begin
      if (k == 3 + 4*b)      key = p1[b];
      else if (k == 4 + 4*b) key = p2[b];
      else if (k == 5 + 4*b) key = 8'h00;
    end
  endtask

  initial begin
    // reset
    tick_n(3);
    chk("rst_lcd", m_lcd, 0);   chk("rst_r", m_r, 2);       chk("rst_g", m_g, 0);
    chk("rst_score", m_score, 0); chk("rst_best", m_best, 0); chk("rst_se", m_se, 0);
    chk("rst_tick", m_tick, 0); chk("rst_sat_r", s_r, 2);
    RESETN = 1'b1;
    tick_n(20);
    chk("hold_lcd", m_lcd, 0); chk("hold_r", m_r, 2); chk("hold_score", m_score, 0);

    // game A: play+score together, one hit, then abort
    sel = 1'b1; menu_play = 1'b1; menu_score = 1'b1;
    set_presses(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int k = 1; k <= 4; k++) step_game(k);
    chk("lcd_pre", m_lcd, 0); chk("addr_entry", rom_if.note_addr, 4);
    step_game(5);
    chk("lcd_play", m_lcd, 1); chk("g_play", m_g, 2); chk("r_play", m_r, 0);
    step_game(6); chk("tick_mid", m_tick, 0);
    step_game(7); chk("tick_last", m_tick, 1); chk("hit_a", m_score, 1); chk("se_a", m_se, 1);
    step_game(8); chk("addr_beat1", rom_if.note_addr, 5); chk("se_a_end", m_se, 0);
    back = 1'b1;
    step_game(9); step_game(10);
    back = 1'b0;
    for (int k = 11; k <= 13; k++) step_game(k);
    chk("lcd_abort", m_lcd, 0); chk("r_abort", m_r, 2);
    chk("best_abort", m_best, 0); chk("score_abort", m_score, 1);

    // score screen and back
    tick_n(4);
    menu_score = 1'b1; tick_n(5);
    chk("lcd_score", m_lcd, 2); chk("b_score", m_b, 2);
    menu_score = 1'b0; back = 1'b1; tick_n(5);
    chk("lcd_back", m_lcd, 0);
    back = 1'b0; tick_n(4);

    // game 1: hits in beats 0,1,3, press on rest beat 2
    se_base = se_cnt;
    sel = 1'b1; menu_play = 1'b1;
    set_presses(8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int k = 1; k <= 5; k++) step_game(k);
    chk("score_clr", m_score, 0);
    for (int k = 6; k <= 21; k++) step_game(k);
    chk("lcd_result", m_lcd, 3); chk("r_result", m_r, 2); chk("g_result", m_g, 2);
    chk("b_result", m_b, 0); chk("score_g1", m_score, 3); chk("best_g1", m_best, 3);
    chk("se_g1", se_cnt - se_base, 3);

    // RESULT left via play, score held
    menu_play = 1'b1; tick_n(5);
    chk("lcd_res_exit", m_lcd, 0); chk("score_hold", m_score, 3);
    menu_play = 1'b0; tick_n(4);

    // game 2: hit beat 0, wrong then right in beat 1, rest press beat 2
    se_base = se_cnt;
    menu_play = 1'b1;
    set_presses(8'h01, 8'h04, 8'h08, 8'h00, 8'h01, 8'h02, 8'h08, 8'h00);
    for (int k = 1; k <= 13; k++) step_game(k);
    chk("judged_once", m_score, 1);
    for (int k = 14; k <= 21; k++) step_game(k);
    chk("lcd_g2", m_lcd, 3); chk("score_g2", m_score, 1); chk("best_g2", m_best, 3);
    chk("se_g2", se_cnt - se_base, 1);

    RESETN = 1'b0; tick_n(2);
    chk("best_rst", m_best, 0);
    RESETN = 1'b1; tick_n(3);

    // saturation game on the SCORE_W=2 instance: six hits, song 0
    sel = 1'b0; menu_play = 1'b1;
    set_presses(8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    p1[4] = 8'h01; p1[5] = 8'h01;
    for (int k = 1; k <= 11; k++) step_game(k);
    chk("sat_two", s_score, 2);
    for (int k = 12; k <= 19; k++) step_game(k);
    chk("sat_four", s_score, 3);
    for (int k = 20; k <= 21; k++) step_game(k);
    chk("main_best4", m_best, 4);
    for (int k = 22; k <= 27; k++) step_game(k);
    chk("sat_six", s_score, 3); chk("sat_se", s_se, 1); chk("sat_lcd", s_lcd, 1);

    // asynchronous reset mid-PLAY, checked before any clock edge
    RESETN = 1'b0; #2;
    chk("arst_lcd", s_lcd, 0); chk("arst_r", s_r, 2); chk("arst_g", s_g, 0);
    chk("arst_score", s_score, 0); chk("arst_se", s_se, 0); chk("arst_best", m_best, 0);
    chk("arst_tick", s_tick, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
